// File: rtl/ntsc_video_generator.sv
// ntsc_video_generator
// Free-running monochrome composite-video timing and pattern generator.
// It produces one progressive 262-line field that repeats continuously.
// The 1-bit luminance and the active-low composite sync outputs feed an
// external resistor DAC.
//
// Optional build macro VIDEO_TEST_PATTERN_EN:
//   defined   -> the active area shows an 8x8-pixel checkerboard (x[3] ^ y[3])
//   undefined -> the active area is solid white
// Timing and sync are identical in both builds.
module ntsc_video_generator #(
    parameter int H_TOTAL        = 2032,
    parameter int H_SYNC         = 150,
    parameter int H_ACTIVE_START = 384,
    parameter int PIXEL_CLOCKS   = 5,
    parameter int H_PIXELS       = 256,
    parameter int V_TOTAL        = 262,
    parameter int V_SYNC_LINES   = 3,
    parameter int V_ACTIVE_START = 32,
    parameter int V_ACTIVE_LINES = 200
) (
    input  logic clock,
    input  logic reset,
    output logic luminance,
    output logic sync
);

    localparam int H_W = $clog2(H_TOTAL);
    localparam int V_W = $clog2(V_TOTAL);
    localparam int S_W = (PIXEL_CLOCKS > 1) ? $clog2(PIXEL_CLOCKS) : 1;
    localparam int X_W = ($clog2(H_PIXELS) > 4) ? $clog2(H_PIXELS) : 4;
    localparam int Y_W = ($clog2(V_ACTIVE_LINES) > 4) ? $clog2(V_ACTIVE_LINES) : 4;

    localparam logic [H_W-1:0] H_LAST      = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_SYNC_END  = H_W'(H_SYNC);
    localparam logic [H_W-1:0] H_BROAD_END = H_W'(H_TOTAL - H_SYNC);
    localparam logic [H_W-1:0] H_ACT_BEG   = H_W'(H_ACTIVE_START);
    localparam logic [H_W-1:0] H_ACT_END   = H_W'(H_ACTIVE_START + H_PIXELS * PIXEL_CLOCKS);
    localparam logic [V_W-1:0] V_LAST      = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_SYNC_END  = V_W'(V_SYNC_LINES);
    localparam logic [V_W-1:0] V_ACT_BEG   = V_W'(V_ACTIVE_START);
    localparam logic [V_W-1:0] V_ACT_END   = V_W'(V_ACTIVE_START + V_ACTIVE_LINES);
    localparam logic [S_W-1:0] S_LAST      = S_W'(PIXEL_CLOCKS - 1);

    // Stage 0: raster position counters
    logic [H_W-1:0] h_p0;
    logic [V_W-1:0] v_p0;
    logic [S_W-1:0] sub_p0;
    logic [X_W-1:0] x_p0;
    logic [Y_W-1:0] y_p0;

    logic line_end;
    logic h_act;
    logic v_act;
    logic vsync_line;
    logic pattern;
    logic sync_nxt;
    logic lum_nxt;

    // Decode the current raster position into sync and luminance levels
    always_comb begin
        line_end   = (h_p0 == H_LAST);
        h_act      = (h_p0 >= H_ACT_BEG) && (h_p0 < H_ACT_END);
        v_act      = (v_p0 >= V_ACT_BEG) && (v_p0 < V_ACT_END);
        vsync_line = (v_p0 < V_SYNC_END);
        // Vertical sync lines carry broad pulses: low for all but the last H_SYNC clocks
        sync_nxt   = vsync_line ? (h_p0 >= H_BROAD_END) : (h_p0 >= H_SYNC_END);
`ifdef VIDEO_TEST_PATTERN_EN
        pattern    = x_p0[3] ^ y_p0[3];
`else
        pattern    = 1'b1;
`endif
        lum_nxt    = h_act && v_act && pattern;
    end

    // Horizontal and vertical counters; v advances on the h wrap
    always_ff @(posedge clock) begin
        if (reset) begin
            h_p0 <= '0;
            v_p0 <= '0;
        end else if (line_end) begin
            h_p0 <= '0;
            v_p0 <= (v_p0 == V_LAST) ? '0 : v_p0 + 1'b1;
        end else begin
            h_p0 <= h_p0 + 1'b1;
        end
    end

    // Pixel sub-counter and x coordinate, held at zero outside the active window
    always_ff @(posedge clock) begin
        if (reset) begin
            sub_p0 <= '0;
            x_p0   <= '0;
        end else if (h_act) begin
            if (sub_p0 == S_LAST) begin
                sub_p0 <= '0;
                x_p0   <= x_p0 + 1'b1;
            end else begin
                sub_p0 <= sub_p0 + 1'b1;
            end
        end else begin
            sub_p0 <= '0;
            x_p0   <= '0;
        end
    end

    // y coordinate: counts active lines, so it equals v - V_ACTIVE_START inside the window
    always_ff @(posedge clock) begin
        if (reset) begin
            y_p0 <= '0;
        end else if (line_end) begin
            y_p0 <= v_act ? y_p0 + 1'b1 : '0;
        end
    end

    // Stage 1: registered outputs, one clock behind the counters
    always_ff @(posedge clock) begin
        if (reset) begin
            luminance <= 1'b0;
            sync      <= 1'b0;
        end else begin
            luminance <= lum_nxt;
            sync      <= sync_nxt;
        end
    end

endmodule

// File: tb/tb_ntsc_video_generator.sv
// tb_ntsc_video_generator
// Self-checking bench: a full-size instance checks reset, vsync line 0,
// blank line 10, active lines 32..40 and a mid-field reset; a scaled-down
// instance checks complete fields, field repetition, the last active line
// and field wrap, and a randomly placed mid-field reset.
`timescale 1ns/1ps
module tb_ntsc_video_generator;

    typedef struct packed {
        int ht; int hs; int has; int pc; int hp; int vt; int vs; int vas; int val;
    } cfg_t;

    localparam int S_HT = 80;
    localparam int S_HS = 6;
    localparam int S_HAS = 16;
    localparam int S_PC = 3;
    localparam int S_HP = 18;
    localparam int S_VT = 36;
    localparam int S_VS = 3;
    localparam int S_VAS = 6;
    localparam int S_VAL = 20;
    localparam int S_FIELD = S_HT * S_VT;

    localparam cfg_t FULL  = '{2032, 150, 384, 5, 256, 262, 3, 32, 200};
    localparam cfg_t SMALL = '{S_HT, S_HS, S_HAS, S_PC, S_HP, S_VT, S_VS, S_VAS, S_VAL};

`ifdef VIDEO_TEST_PATTERN_EN
    localparam bit PAT = 1'b1;
`else
    localparam bit PAT = 1'b0;
`endif

    logic clock;
    logic reset_f, reset_s;
    logic lum_f, sync_f, lum_s, sync_s;

    int checks = 0;
    int errors = 0;
    int pos_f = 0;
    int pos_s = 0;
    logic [1:0] field1 [0:S_FIELD-1];

    ntsc_video_generator dut_full (
        .clock     (clock),
        .reset     (reset_f),
        .luminance (lum_f),
        .sync      (sync_f)
    );

    ntsc_video_generator #(
        .H_TOTAL        (S_HT),
        .H_SYNC         (S_HS),
        .H_ACTIVE_START (S_HAS),
        .PIXEL_CLOCKS   (S_PC),
        .H_PIXELS       (S_HP),
        .V_TOTAL        (S_VT),
        .V_SYNC_LINES   (S_VS),
        .V_ACTIVE_START (S_VAS),
        .V_ACTIVE_LINES (S_VAL)
    ) dut_small (
        .clock     (clock),
        .reset     (reset_s),
        .luminance (lum_s),
        .sync      (sync_s)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: expected outputs for raster position t counted from the start of a field
    function automatic void model(input cfg_t c, input int t, output logic s, output logic l);
        int h, v;
        h = t % c.ht;
        v = (t / c.ht) % c.vt;
        if (v < c.vs) s = (h >= c.ht - c.hs);
        else          s = (h >= c.hs);
        l = 1'b0;
        if (v >= c.vas && v < c.vas + c.val && h >= c.has && h < c.has + c.hp * c.pc) begin
`ifdef VIDEO_TEST_PATTERN_EN
            l = (((h - c.has) / c.pc / 8) % 2) != (((v - c.vas) / 8) % 2);
`else
            l = 1'b1;
`endif
        end
    endfunction

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        logic es, el;
        reset_f = 1'b1;
        repeat (3) begin
            step();
            checks++;
            if ({sync_f, lum_f} !== 2'b00) begin
                errors++;
                $display("FAIL reset_hold sync=%b lum=%b required sync=0 lum=0", sync_f, lum_f);
            end
        end
        reset_f = 1'b0;
        pos_f = 0;
        // line 0 is a vsync line: low through h=1881, high from h=1882
        while (pos_f < FULL.ht) begin
            step();
            model(FULL, pos_f, es, el);
            checks++;
            if ({sync_f, lum_f} !== {es, el}) begin
                errors++;
                $display("FAIL line0 pos=%0d sync=%b lum=%b required sync=%b lum=%b", pos_f, sync_f, lum_f, es, el);
            end
            if (pos_f == 0 || pos_f == 1881 || pos_f == 1882) begin
                checks++;
                if (sync_f !== (pos_f == 1882) || lum_f !== 1'b0) begin
                    errors++;
                    $display("FAIL vsync_edge h=%0d sync=%b lum=%b required sync=%b lum=0", pos_f, sync_f, lum_f, pos_f == 1882);
                end
            end
            pos_f++;
        end
    endtask

    task automatic test_blank_line();
        logic es, el;
        int lows, first_high, lum_ones;
        lows = 0; first_high = -1; lum_ones = 0;
        while (pos_f < 11 * FULL.ht) begin
            step();
            model(FULL, pos_f, es, el);
            checks++;
            if ({sync_f, lum_f} !== {es, el}) begin
                errors++;
                $display("FAIL lines1_10 pos=%0d sync=%b lum=%b required sync=%b lum=%b", pos_f, sync_f, lum_f, es, el);
            end
            if (pos_f >= 10 * FULL.ht) begin
                if (sync_f === 1'b0) lows++;
                else if (first_high < 0) first_high = pos_f - 10 * FULL.ht;
                if (lum_f !== 1'b0) lum_ones++;
            end
            pos_f++;
        end
        checks++;
        if (lows != 150 || first_high != 150 || lum_ones != 0) begin
            errors++;
            $display("FAIL line10 sync_low=%0d first_high=%0d lum_ones=%0d required 150 150 0", lows, first_high, lum_ones);
        end
    endtask

    task automatic test_active_line();
        logic es, el;
        int h;
        while (pos_f < 33 * FULL.ht) begin
            step();
            model(FULL, pos_f, es, el);
            checks++;
            if ({sync_f, lum_f} !== {es, el}) begin
                errors++;
                $display("FAIL lines11_32 pos=%0d sync=%b lum=%b required sync=%b lum=%b", pos_f, sync_f, lum_f, es, el);
            end
            h = pos_f - 32 * FULL.ht;
            if (h == 383 || h == 1664) begin
                checks++;
                if (lum_f !== 1'b0) begin
                    errors++;
                    $display("FAIL line32_blank h=%0d lum=%b required 0", h, lum_f);
                end
            end
            if (h == 384 || h == 423) begin
                checks++;
                if (lum_f !== !PAT) begin
                    errors++;
                    $display("FAIL line32_px0 h=%0d lum=%b required %b", h, lum_f, !PAT);
                end
            end
            if (h == 424 || h == 463) begin
                checks++;
                if (lum_f !== 1'b1) begin
                    errors++;
                    $display("FAIL line32_px8 h=%0d lum=%b required 1", h, lum_f);
                end
            end
            if (h == 149 || h == 150) begin
                checks++;
                if (sync_f !== (h == 150)) begin
                    errors++;
                    $display("FAIL line32_sync h=%0d sync=%b required %b", h, sync_f, h == 150);
                end
            end
            pos_f++;
        end
    endtask

    task automatic test_checker_phase();
        logic es, el;
        int h;
        while (pos_f < 41 * FULL.ht) begin
            step();
            model(FULL, pos_f, es, el);
            checks++;
            if ({sync_f, lum_f} !== {es, el}) begin
                errors++;
                $display("FAIL lines33_40 pos=%0d sync=%b lum=%b required sync=%b lum=%b", pos_f, sync_f, lum_f, es, el);
            end
            h = pos_f - 40 * FULL.ht;
            if (h == 384 || h == 423 || h == 424) begin
                checks++;
                if (lum_f !== ((h < 424) ? 1'b1 : !PAT)) begin
                    errors++;
                    $display("FAIL line40_phase h=%0d lum=%b required %b", h, lum_f, (h < 424) ? 1'b1 : !PAT);
                end
            end
            pos_f++;
        end
    endtask

    task automatic test_reset_full_midfield();
        logic es, el;
        int adv, hold;
        adv = $urandom_range(0, 499);
        hold = $urandom_range(1, 4);
        repeat (adv) begin
            step();
            model(FULL, pos_f, es, el);
            checks++;
            if ({sync_f, lum_f} !== {es, el}) begin
                errors++;
                $display("FAIL line41 pos=%0d sync=%b lum=%b required sync=%b lum=%b", pos_f, sync_f, lum_f, es, el);
            end
            pos_f++;
        end
        reset_f = 1'b1;
        repeat (hold) begin
            step();
            checks++;
            if ({sync_f, lum_f} !== 2'b00) begin
                errors++;
                $display("FAIL full_midreset_hold sync=%b lum=%b required 00", sync_f, lum_f);
            end
        end
        reset_f = 1'b0;
        for (int t = 0; t < 300; t++) begin
            step();
            model(FULL, t, es, el);
            checks++;
            if ({sync_f, lum_f} !== {es, el}) begin
                errors++;
                $display("FAIL full_after_reset pos=%0d sync=%b lum=%b required sync=%b lum=%b", t, sync_f, lum_f, es, el);
            end
        end
    endtask

    task automatic test_field_repeat();
        logic es, el;
        int vs_lines [0:1];
        int lum26, f, p;
        vs_lines[0] = 0; vs_lines[1] = 0; lum26 = 0;
        reset_s = 1'b1;
        repeat (2) step();
        reset_s = 1'b0;
        pos_s = 0;
        while (pos_s < 2 * S_FIELD) begin
            step();
            model(SMALL, pos_s, es, el);
            f = pos_s / S_FIELD;
            p = pos_s % S_FIELD;
            checks++;
            if ({sync_s, lum_s} !== {es, el}) begin
                errors++;
                $display("FAIL small_field pos=%0d sync=%b lum=%b required sync=%b lum=%b", pos_s, sync_s, lum_s, es, el);
            end
            if (f == 0) begin
                field1[p] = {sync_s, lum_s};
            end else begin
                checks++;
                if ({sync_s, lum_s} !== field1[p]) begin
                    errors++;
                    $display("FAIL field_repeat pos=%0d got=%b first_field=%b", p, {sync_s, lum_s}, field1[p]);
                end
            end
            if (p % S_HT == S_HS && sync_s === 1'b0) vs_lines[f]++;
            if (f == 0 && p / S_HT == 26 && lum_s !== 1'b0) lum26++;
            if (f == 0 && (p == 25 * S_HT + 69 || p == 25 * S_HT + 70)) begin
                // last active pixel x=17,y=19 is dark in the checkerboard
                checks++;
                if (lum_s !== ((p == 25 * S_HT + 69) ? !PAT : 1'b0)) begin
                    errors++;
                    $display("FAIL last_active p=%0d lum=%b required %b", p, lum_s, (p == 25 * S_HT + 69) ? !PAT : 1'b0);
                end
            end
            if (p == 35 * S_HT + 10 || (f == 1 && p == 10)) begin
                checks++;
                if (sync_s !== (p != 10)) begin
                    errors++;
                    $display("FAIL field_wrap p=%0d sync=%b required %b", p, sync_s, p != 10);
                end
            end
            pos_s++;
        end
        checks++;
        if (vs_lines[0] != 3 || vs_lines[1] != 3 || lum26 != 0) begin
            errors++;
            $display("FAIL vsync_count field0=%0d field1=%0d line26_lum=%0d required 3 3 0", vs_lines[0], vs_lines[1], lum26);
        end
    endtask

    task automatic test_back_to_back_reset();
        logic es, el;
        int adv, hold;
        adv = $urandom_range(10 * S_HT, 20 * S_HT);
        hold = $urandom_range(1, 4);
        repeat (adv) begin
            step();
            model(SMALL, pos_s, es, el);
            checks++;
            if ({sync_s, lum_s} !== {es, el}) begin
                errors++;
                $display("FAIL small_pre_reset pos=%0d sync=%b lum=%b required sync=%b lum=%b", pos_s, sync_s, lum_s, es, el);
            end
            pos_s++;
        end
        reset_s = 1'b1;
        repeat (hold) begin
            step();
            checks++;
            if ({sync_s, lum_s} !== 2'b00) begin
                errors++;
                $display("FAIL small_midreset_hold sync=%b lum=%b required 00", sync_s, lum_s);
            end
        end
        reset_s = 1'b0;
        for (int t = 0; t < 8 * S_HT; t++) begin
            step();
            model(SMALL, t, es, el);
            checks++;
            if ({sync_s, lum_s} !== {es, el}) begin
                errors++;
                $display("FAIL small_after_reset pos=%0d sync=%b lum=%b required sync=%b lum=%b", t, sync_s, lum_s, es, el);
            end
        end
    endtask

    initial begin
        reset_f = 1'b1;
        reset_s = 1'b1;
        test_reset();
        test_blank_line();
        test_active_line();
        test_checker_phase();
        test_reset_full_midfield();
        test_field_repeat();
        test_back_to_back_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
